// File: rtl/lane_incrementer.sv
// lane_incrementer: per-lane wrap/saturate increment feeding a DEPTH-entry valid/ready FIFO
module lane_incrementer #(
  parameter int          LANES = 4,
  parameter int          WIDTH = 40,
  parameter logic [63:0] STEP  = 64'd1,
  parameter int          DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_ovf,
  output logic [31:0]            beat_count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]              wr_ptr, rd_ptr;
  logic [LANES*WIDTH-1:0]   mem_data [DEPTH];
  logic [LANES-1:0]         mem_ovf [DEPTH];
  logic [LANES*WIDTH-1:0]   res;
  logic [LANES-1:0]         ovf;
  logic [AW-1:0]            head;
  logic                     push, pop;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH:0] sum;
    assign sum = {1'b0, in_data[g*WIDTH +: WIDTH]} + (WIDTH+1)'(STEP);
    assign ovf[g] = sum[WIDTH];
    assign res[g*WIDTH +: WIDTH] = (in_sat && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
  end
  assign in_ready  = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
  assign out_valid = wr_ptr != rd_ptr;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // when empty, show the slot just popped so the outputs hold their last contents
  assign head      = out_valid ? rd_ptr[AW-1:0] : AW'(rd_ptr[AW-1:0] - 1'b1);
  assign out_data  = mem_data[head];
  assign out_ovf   = mem_ovf[head];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beat_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_ovf[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr[AW-1:0]] <= res;
        mem_ovf[wr_ptr[AW-1:0]]  <= ovf;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        beat_count <= beat_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_lane_incrementer.sv
// tb_lane_incrementer: directed stimulus checked every cycle against a queue-based model
module tb_lane_incrementer;
  localparam int LANES = 4;
  localparam int WIDTH = 40;
  localparam longint unsigned STEP = 1;
  localparam int DEPTH = 4;
  localparam int DW = LANES*WIDTH;
  typedef struct { logic [DW-1:0] d; logic [LANES-1:0] o; } beat_t;

  logic clk = 0, reset = 1, in_valid = 0, in_sat = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [LANES-1:0] out_ovf;
  logic [31:0] beat_count;
  int errors = 0, checks = 0;
  beat_t q[$];
  logic [31:0] mcount = 0;

  lane_incrementer #(.LANES(LANES), .WIDTH(WIDTH), .STEP(64'(STEP)), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sat(in_sat), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .beat_count(beat_count));

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic beat_t expect_beat(input logic [DW-1:0] d, input logic sat);
    beat_t b;
    longint unsigned mx = (64'd1 << WIDTH) - 1;
    for (int i = 0; i < LANES; i++) begin
      logic [64:0] s = 65'(d[i*WIDTH +: WIDTH]) + 65'(STEP);
      b.o[i] = s > 65'(mx);
      b.d[i*WIDTH +: WIDTH] = !b.o[i] ? WIDTH'(s) : sat ? WIDTH'(mx) : WIDTH'(s - 65'(mx) - 65'd1);
    end
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mcount = 0;
    end else begin
      bit pu, po;
      pu = in_valid && q.size() < DEPTH;
      po = out_ready && q.size() > 0;
      if (po) begin
        void'(q.pop_front());
        mcount++;
      end
      if (pu) q.push_back(expect_beat(in_data, in_sat));
    end
  end

  always @(negedge clk) begin
    check("in_ready", DW'(in_ready), DW'(q.size() != DEPTH));
    check("out_valid", DW'(out_valid), DW'(q.size() != 0));
    check("beat_count", DW'(beat_count), DW'(mcount));
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].d);
      check("out_ovf", DW'(out_ovf), DW'(q[0].o));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int acc;
    $display("lane_incrementer LANES=%0d WIDTH=%0d DEPTH=%0d", LANES, WIDTH, DEPTH);
    repeat (2) tick();
    reset = 0;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", DW'(out_ovf), '0);
    check("rst_beat_count", DW'(beat_count), '0);
    tick();
    // basic increment with one-cycle latency
    in_data = {40'd7, 40'hFF_FFFF_FFFE, 40'd5, 40'd0};
    in_sat = 0; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    check("t1_valid", DW'(out_valid), DW'(1));
    check("t1_data", out_data, {40'd8, 40'hFF_FFFF_FFFF, 40'd6, 40'd1});
    check("t1_ovf", DW'(out_ovf), '0);
    tick();
    check("t1_count", DW'(beat_count), DW'(1));
    // wrap then saturate on all-ones lanes
    in_data = {40'd3, 40'hFF_FFFF_FFFF, 40'd10, 40'hFF_FFFF_FFFF};
    in_valid = 1; in_sat = 0;
    tick();
    check("t2_wrap_data", out_data, {40'd4, 40'd0, 40'd11, 40'd0});
    check("t2_wrap_ovf", DW'(out_ovf), DW'(4'b0101));
    in_sat = 1;
    tick();
    in_valid = 0;
    check("t2_sat_data", out_data, {40'd4, 40'hFF_FFFF_FFFF, 40'd11, 40'hFF_FFFF_FFFF});
    check("t2_sat_ovf", DW'(out_ovf), DW'(4'b0101));
    tick();
    // fill with consumer stalled
    out_ready = 0; in_valid = 1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = {40'(i*3), 40'hFF_FFFF_FFFF - 40'(i%2), 40'(i), 40'(i*7)};
      in_sat = i[0];
      if (in_ready) acc++;
      tick();
    end
    in_valid = 0;
    check("t3_accepted", DW'(acc), DW'(4));
    check("t3_full", DW'(in_ready), '0);
    out_ready = 1;
    repeat (4) tick();
    check("t3_drained_ready", DW'(in_ready), DW'(1));
    check("t3_drained_valid", DW'(out_valid), '0);
    // full FIFO: pop only, then sustained push+pop at occupancy 3
    out_ready = 0; in_valid = 1;
    repeat (4) tick();
    out_ready = 1;
    tick();
    check("t4_occ_after_pop", DW'(q.size()), DW'(3));
    check("t4_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < 100; i++) begin
      in_data = {40'(i), 40'hFF_FFFF_FFFF - 40'(i%3), 40'(i*11), 40'(1000-i)};
      in_sat = i[1];
      tick();
    end
    check("t4_occ_stream", DW'(q.size()), DW'(3));
    in_valid = 0;
    repeat (3) tick();
    // asynchronous reset with entries queued
    out_ready = 0; in_valid = 1;
    repeat (3) tick();
    in_valid = 0;
    @(posedge clk);
    #4 reset = 1;
    #1;
    check("t5_valid_drop", DW'(out_valid), '0);
    check("t5_count", DW'(beat_count), '0);
    tick();
    reset = 0;
    out_ready = 1;
    repeat (3) tick();
    check("t5_no_stale", DW'(out_valid), '0);
    // beat_count wrap
    out_ready = 0; in_valid = 1; in_data = '0;
    tick();
    in_valid = 0;
    force dut.beat_count = 32'hFFFF_FFFF;
    mcount = 32'hFFFF_FFFF;
    #1 release dut.beat_count;
    tick();
    check("t6_preload", DW'(beat_count), DW'(32'hFFFF_FFFF));
    out_ready = 1;
    tick();
    check("t6_wrap", DW'(beat_count), '0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
